// File: rtl/uart_param_core.sv
// UART with TX/RX FIFOs, a 16x-oversampled baud tick, and optional parity.
// Optional parity is selected by defining the UART_PARITY_EN macro.
module uart_param_core #(
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 tx_busy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 rx_overrun
);

  localparam int DIV_RAW = CLK_HZ / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = $clog2(DIV + 1);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  // Free-running baud divider
  logic [CW-1:0] baud_cnt;
  logic          tick;

  assign tick = (baud_cnt == CW'(DIV));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    baud_cnt <= CW'(1);
    else if (tick) baud_cnt <= CW'(1);
    else           baud_cnt <= baud_cnt + CW'(1);
  end

  // TX FIFO
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AW:0]          tx_wr, tx_rd;
  logic                 tx_full, tx_empty, tx_push, tx_pop, rdy_en;
  state_t               tx_state;
  logic [3:0]           tx_cnt;
  logic [2:0]           tx_bit;
  logic                 tx_stop, tx_armed;
  logic [DATA_BITS-1:0] tx_shift;

  assign tx_full  = (tx_wr[AW] != tx_rd[AW]) && (tx_wr[AW-1:0] == tx_rd[AW-1:0]);
  assign tx_empty = (tx_wr == tx_rd);
  assign tx_ready = rdy_en && !tx_full;
  assign tx_push  = tx_valid && tx_ready;
  assign tx_pop   = !tx_empty && ((tx_state == IDLE) ||
                    (tx_state == STOP && tick && tx_cnt == 4'd15 && tx_stop == LAST_STOP));
  assign tx_busy  = !tx_empty || (tx_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr[AW-1:0]] <= tx_data;
  end

`ifdef UART_PARITY_EN
  logic tx_par;
  always_ff @(posedge clk) begin
    if (tx_pop) tx_par <= parity_of(tx_mem[tx_rd[AW-1:0]]);
  end
`endif

  always_ff @(posedge clk) begin
    if (tx_pop)
      tx_shift <= tx_mem[tx_rd[AW-1:0]];
    else if (tick && tx_state == DATA && tx_cnt == 4'd15)
      tx_shift <= tx_shift >> 1;
  end

  // TX FSM: a bit boundary falls on every 16th tick; tx_armed marks that the start bit is on the line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= IDLE;
      txd      <= 1'b1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_stop  <= 1'b0;
      tx_armed <= 1'b0;
    end else begin
      case (tx_state)
        IDLE: if (tx_pop) begin
          tx_state <= START;
          tx_armed <= 1'b0;
          tx_cnt   <= '0;
        end
        START: if (tick) begin
          if (!tx_armed) begin
            txd      <= 1'b0;
            tx_armed <= 1'b1;
            tx_cnt   <= '0;
          end else if (tx_cnt == 4'd15) begin
            txd      <= tx_shift[0];
            tx_state <= DATA;
            tx_cnt   <= '0;
            tx_bit   <= '0;
          end else begin
            tx_cnt <= tx_cnt + 4'd1;
          end
        end
        DATA: if (tick) begin
          if (tx_cnt == 4'd15) begin
            tx_cnt <= '0;
            if (tx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
              tx_state <= PARITY;
              txd      <= tx_par;
`else
              tx_state <= STOP;
              txd      <= 1'b1;
              tx_stop  <= 1'b0;
`endif
            end else begin
              tx_bit <= tx_bit + 3'd1;
              txd    <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 4'd1;
          end
        end
`ifdef UART_PARITY_EN
        PARITY: if (tick) begin
          if (tx_cnt == 4'd15) begin
            tx_state <= STOP;
            txd      <= 1'b1;
            tx_stop  <= 1'b0;
            tx_cnt   <= '0;
          end else begin
            tx_cnt <= tx_cnt + 4'd1;
          end
        end
`endif
        STOP: if (tick) begin
          if (tx_cnt == 4'd15) begin
            tx_cnt <= '0;
            if (tx_stop == LAST_STOP) begin
              if (tx_pop) begin
                tx_state <= START;
                tx_armed <= 1'b1;
                txd      <= 1'b0;
              end else begin
                tx_state <= IDLE;
              end
            end else begin
              tx_stop <= 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 4'd1;
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  // RX synchronizer
  logic rx_s1, rx_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
    end
  end

  state_t               rx_state;
  logic [3:0]           rx_cnt;
  logic [2:0]           rx_bit;
  logic                 rx_wait, rx_push;
  logic [DATA_BITS-1:0] rx_shift;

  always_ff @(posedge clk) begin
    if (tick && rx_state == DATA && rx_cnt == 4'd8)
      rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
  end

`ifdef UART_PARITY_EN
  logic rx_par, parity_err_r;
  assign parity_err = parity_err_r;
  always_ff @(posedge clk) begin
    if (tick && rx_state == PARITY && rx_cnt == 4'd8) rx_par <= rx_s2;
  end
`else
  assign parity_err = 1'b0;
`endif

  // RX FSM: rx_cnt counts ticks from the start-bit edge, 16 per bit period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state  <= IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_wait   <= 1'b0;
      rx_push   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      parity_err_r <= 1'b0;
`endif
    end else begin
      rx_push   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      parity_err_r <= 1'b0;
`endif
      case (rx_state)
        IDLE: if (!rx_s2) begin
          rx_state <= START;
          rx_cnt   <= '0;
        end
        START: if (tick) begin
          if (rx_cnt == 4'd7 && rx_s2) begin
            rx_state <= IDLE;
          end else if (rx_cnt == 4'd15) begin
            rx_state <= DATA;
            rx_cnt   <= '0;
            rx_bit   <= '0;
          end else begin
            rx_cnt <= rx_cnt + 4'd1;
          end
        end
        DATA: if (tick) begin
          if (rx_cnt == 4'd15) begin
            rx_cnt <= '0;
            if (rx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
              rx_state <= PARITY;
`else
              rx_state <= STOP;
`endif
            end else begin
              rx_bit <= rx_bit + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + 4'd1;
          end
        end
`ifdef UART_PARITY_EN
        PARITY: if (tick) begin
          if (rx_cnt == 4'd15) begin
            rx_state <= STOP;
            rx_cnt   <= '0;
          end else begin
            rx_cnt <= rx_cnt + 4'd1;
          end
        end
`endif
        STOP: begin
          if (rx_wait) begin
            if (rx_s2) begin
              rx_wait  <= 1'b0;
              rx_state <= IDLE;
            end
          end else if (tick) begin
            if (rx_cnt == 4'd8) begin
              if (!rx_s2) begin
                frame_err <= 1'b1;
                rx_wait   <= 1'b1;
              end else begin
`ifdef UART_PARITY_EN
                if (rx_par != parity_of(rx_shift)) parity_err_r <= 1'b1;
                else                               rx_push      <= 1'b1;
`else
                rx_push <= 1'b1;
`endif
                rx_state <= IDLE;
              end
            end else begin
              rx_cnt <= rx_cnt + 4'd1;
            end
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  // RX FIFO: a pop frees the slot that a same-cycle push into a full FIFO takes
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]          rx_wr, rx_rd;
  logic                 rx_full, rx_pop, rx_wr_en;

  assign rx_full  = (rx_wr[AW] != rx_rd[AW]) && (rx_wr[AW-1:0] == rx_rd[AW-1:0]);
  assign rx_valid = (rx_wr != rx_rd);
  assign rx_pop   = rx_valid && rx_ready;
  assign rx_wr_en = rx_push && (!rx_full || rx_pop);
  assign rx_data  = rx_mem[rx_rd[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr      <= '0;
      rx_rd      <= '0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= rx_push && rx_full && !rx_pop;
      if (rx_wr_en) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)   rx_rd <= rx_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_wr_en) rx_mem[rx_wr[AW-1:0]] <= rx_shift;
  end

endmodule

// File: tb/tb_uart_param_core.sv
// Self-checking bench for uart_param_core: serial framing, FIFOs, loopback and RX error paths.
module tb_uart_param_core;
  localparam int CLK_HZ     = 25000000;
  localparam int BAUD       = 115200;
  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
  localparam int FIFO_DEPTH = 16;
  localparam int PODD       = 0;
  localparam int DIV        = CLK_HZ / (BAUD * 16);
  localparam int BIT        = 16 * DIV;
`ifdef UART_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  localparam int FB = 1 + DATA_BITS + PAR_EN + STOP_BITS;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [DATA_BITS-1:0] tx_data = '0;
  logic                 tx_valid = 1'b0;
  logic                 rx_ready = 1'b0;
  logic                 loop_en = 1'b0;
  logic                 rxd_drv = 1'b1;
  logic                 tx_ready, txd, rxd, rx_valid, tx_busy;
  logic                 frame_err, parity_err, rx_overrun;
  logic [DATA_BITS-1:0] rx_data;

  int tests = 0;
  int fails = 0;
  int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0;

  assign rxd = loop_en ? txd : rxd_drv;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_err)  fe_cnt <= fe_cnt + 1;
    if (parity_err) pe_cnt <= pe_cnt + 1;
    if (rx_overrun) ov_cnt <= ov_cnt + 1;
  end

  uart_param_core #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DATA_BITS), .STOP_BITS(STOP_BITS),
    .FIFO_DEPTH(FIFO_DEPTH), .PARITY_ODD(PODD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .txd(txd), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_busy(tx_busy), .frame_err(frame_err), .parity_err(parity_err), .rx_overrun(rx_overrun)
  );

  // Line level of bit slot idx of a frame carrying d: start, data LSB first, parity, stops
  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DATA_BITS) return d[3'(idx - 1)];
    if (PAR_EN != 0 && idx == DATA_BITS + 1) return (^d[DATA_BITS-1:0]) ^ (PODD != 0);
    return 1'b1;
  endfunction

  task automatic push_byte(input logic [7:0] d);
    int w = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && w < 4 * FB * BIT) begin
      @(negedge clk);
      w++;
    end
    if (tx_ready !== 1'b1) begin
      tests++; fails++;
      $display("FAIL push_timeout byte %h tx_ready=%b want 1", d, tx_ready);
    end
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_txd_low(input string nm);
    int w = 0;
    while (txd !== 1'b0 && w < 4 * FB * BIT) begin
      @(negedge clk);
      w++;
    end
    if (txd !== 1'b0) begin
      tests++; fails++;
      $display("FAIL %s start_timeout txd=%b want 0", nm, txd);
    end
  endtask

  task automatic expect_tx_frame(input logic [7:0] exp, input string nm);
    logic [7:0] got = '0;
    wait_txd_low(nm);
    repeat (BIT / 2) @(negedge clk);
    tests++;
    if (txd !== 1'b0) begin fails++; $display("FAIL %s start_bit got %b want 0", nm, txd); end
    for (int i = 0; i < DATA_BITS; i++) begin
      repeat (BIT) @(negedge clk);
      got[3'(i)] = txd;
    end
    if (PAR_EN != 0) begin
      repeat (BIT) @(negedge clk);
      tests++;
      if (txd !== frame_bit(exp, DATA_BITS + 1)) begin
        fails++; $display("FAIL %s parity_bit got %b want %b", nm, txd, frame_bit(exp, DATA_BITS + 1));
      end
    end
    for (int s = 0; s < STOP_BITS; s++) begin
      repeat (BIT) @(negedge clk);
      tests++;
      if (txd !== 1'b1) begin fails++; $display("FAIL %s stop_bit got %b want 1", nm, txd); end
    end
    tests++;
    if (got !== exp) begin fails++; $display("FAIL %s data got %h want %h", nm, got, exp); end
  endtask

  task automatic drive_rx_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok);
    logic lvl;
    for (int b = 0; b < FB; b++) begin
      lvl = frame_bit(d, b);
      if (PAR_EN != 0 && b == DATA_BITS + 1 && !par_ok) lvl = ~lvl;
      if (b == DATA_BITS + 1 + PAR_EN && !stop_ok) lvl = 1'b0;
      rxd_drv = lvl;
      repeat (BIT) @(negedge clk);
    end
    rxd_drv = 1'b1;
  endtask

  task automatic pop_rx();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic check_head(input logic [7:0] exp, input string nm);
    tests++;
    if (rx_valid !== 1'b1 || rx_data !== exp[DATA_BITS-1:0]) begin
      fails++; $display("FAIL %s rx_valid=%b rx_data=%h want valid=1 data=%h", nm, rx_valid, rx_data, exp);
    end
  endtask

  task automatic check_empty(input string nm);
    tests++;
    if (rx_valid !== 1'b0) begin fails++; $display("FAIL %s rx_valid got %b want 0", nm, rx_valid); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (txd !== 1'b1 || tx_ready !== 1'b0 || rx_valid !== 1'b0 || tx_busy !== 1'b0) begin
      fails++; $display("FAIL reset_outputs txd=%b tx_ready=%b rx_valid=%b tx_busy=%b want 1,0,0,0",
                        txd, tx_ready, rx_valid, tx_busy);
    end
    tests++;
    if ({frame_err, parity_err, rx_overrun} !== 3'b000) begin
      fails++; $display("FAIL reset_errors got %b want 000", {frame_err, parity_err, rx_overrun});
    end
    rst_n = 1'b1;
    #1;
    tests++;
    if (tx_ready !== 1'b0) begin fails++; $display("FAIL ready_before_clk got %b want 0", tx_ready); end
    @(negedge clk);
    tests++;
    if (tx_ready !== 1'b1) begin fails++; $display("FAIL ready_after_clk got %b want 1", tx_ready); end
  endtask

  task automatic test_tx_55();
    logic txd_w  [(FB + 1) * BIT];
    logic busy_w [(FB + 1) * BIT];
    int   bad;
    logic lvl;
    push_byte(8'h55);
    wait_txd_low("tx55");
    for (int c = 0; c < (FB + 1) * BIT; c++) begin
      txd_w[c]  = txd;
      busy_w[c] = tx_busy;
      @(negedge clk);
    end
    for (int b = 0; b <= FB; b++) begin
      lvl = (b < FB) ? frame_bit(8'h55, b) : 1'b1;
      bad = 0;
      for (int c = b * BIT; c < (b + 1) * BIT; c++) if (txd_w[c] !== lvl) bad++;
      tests++;
      if (bad != 0) begin fails++; $display("FAIL tx55_slot%0d %0d cycles off level, want %b for %0d clk", b, bad, lvl, BIT); end
    end
    tests++;
    if (busy_w[FB * BIT - 1] !== 1'b1 || busy_w[FB * BIT] !== 1'b0) begin
      fails++; $display("FAIL tx55_busy_fall got %b,%b want 1,0", busy_w[FB * BIT - 1], busy_w[FB * BIT]);
    end
  endtask

  task automatic test_reset_midframe();
    int lows = 0;
    push_byte(8'hC3);
    push_byte(8'h3C);
    wait_txd_low("midframe");
    repeat (BIT + 7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (txd !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b0) begin
      fails++; $display("FAIL async_reset txd=%b tx_busy=%b tx_ready=%b want 1,0,0", txd, tx_busy, tx_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < (FB + 1) * BIT; c++) begin
      @(negedge clk);
      if (txd === 1'b0) lows++;
    end
    tests++;
    if (lows != 0 || tx_busy !== 1'b0) begin
      fails++; $display("FAIL fifo_discard txd low %0d cycles tx_busy=%b want 0,0", lows, tx_busy);
    end
  endtask

  task automatic test_fifo_full_overrun();
    int ov0 = ov_cnt;
    loop_en  = 1'b1;
    rx_ready = 1'b0;
    for (int i = 0; i <= 16; i++) push_byte(8'(i));
    tests++;
    if (tx_ready !== 1'b0) begin fails++; $display("FAIL tx_full_ready got %b want 0", tx_ready); end
    for (int i = 0; i <= 16; i++) expect_tx_frame(8'(i), "burst");
    repeat (BIT) @(negedge clk);
    tests++;
    if (ov_cnt - ov0 != 1) begin fails++; $display("FAIL overrun_pulses got %0d want 1", ov_cnt - ov0); end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      check_head(8'(i), "burst_rx");
      pop_rx();
    end
    check_empty("burst_rx_drained");
    loop_en = 1'b0;
  endtask

  task automatic test_loopback_pair();
    loop_en = 1'b1;
    push_byte(8'hA3);
    push_byte(8'h3C);
    expect_tx_frame(8'hA3, "pair0");
    expect_tx_frame(8'h3C, "pair1");
    repeat (BIT) @(negedge clk);
    check_head(8'hA3, "pair_head0");
    pop_rx();
    check_head(8'h3C, "pair_head1");
    pop_rx();
    check_empty("pair_empty");
    loop_en = 1'b0;
  endtask

  task automatic test_random_loopback();
    logic [7:0] q[$];
    logic [7:0] d;
    loop_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(0, 255));
      q.push_back(d);
      push_byte(d);
    end
    for (int i = 0; i < 4; i++) expect_tx_frame(q[i], "rand_tx");
    repeat (BIT) @(negedge clk);
    while (q.size() > 0) begin
      d = q.pop_front();
      check_head(d, "rand_rx");
      pop_rx();
    end
    check_empty("rand_empty");
    loop_en = 1'b0;
  endtask

  task automatic test_glitch();
    int fe0 = fe_cnt, pe0 = pe_cnt, ov0 = ov_cnt;
    rxd_drv = 1'b0;
    repeat (4 * DIV) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check_empty("glitch_no_push");
    tests++;
    if (fe_cnt != fe0 || pe_cnt != pe0 || ov_cnt != ov0) begin
      fails++; $display("FAIL glitch_errors fe=%0d pe=%0d ov=%0d want 0,0,0", fe_cnt - fe0, pe_cnt - pe0, ov_cnt - ov0);
    end
    drive_rx_frame(8'h5A, 1'b1, 1'b1);
    repeat (BIT) @(negedge clk);
    check_head(8'h5A, "after_glitch");
    pop_rx();
  endtask

  task automatic test_frame_error();
    int fe0 = fe_cnt;
    drive_rx_frame(8'h81, 1'b0, 1'b1);
    repeat (BIT) @(negedge clk);
    tests++;
    if (fe_cnt - fe0 != 1) begin fails++; $display("FAIL frame_err_pulses got %0d want 1", fe_cnt - fe0); end
    check_empty("frame_err_discard");
    drive_rx_frame(8'h7E, 1'b1, 1'b1);
    repeat (BIT) @(negedge clk);
    check_head(8'h7E, "after_frame_err");
    pop_rx();
    tests++;
    if (fe_cnt - fe0 != 1) begin fails++; $display("FAIL frame_err_total got %0d want 1", fe_cnt - fe0); end
  endtask

  task automatic test_parity();
`ifdef UART_PARITY_EN
    int pe0 = pe_cnt;
    drive_rx_frame(8'h07, 1'b1, 1'b0);
    repeat (BIT) @(negedge clk);
    tests++;
    if (pe_cnt - pe0 != 1) begin fails++; $display("FAIL parity_err_pulses got %0d want 1", pe_cnt - pe0); end
    check_empty("parity_discard");
`else
    tests++;
    if (pe_cnt != 0 || parity_err !== 1'b0) begin
      fails++; $display("FAIL parity_tied pulses=%0d now=%b want 0,0", pe_cnt, parity_err);
    end
`endif
  endtask

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tx_55();
    test_reset_midframe();
    test_fifo_full_overrun();
    test_loopback_pair();
    test_random_loopback();
    test_glitch();
    test_frame_error();
    test_parity();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
